// File: rtl/gpr_wb_ctrl.sv
// gpr_wb_ctrl: register-file write-back controller.
// Merges ALU results (strict priority) and buffered LSU results onto the single
// register-file write port. Tracks registers with outstanding long-latency writes.
// Optional performance counters are enabled by defining GPR_WB_PERF_CNT_EN.
module gpr_wb_ctrl #(
  parameter int unsigned WORD_WIDTH     = 32,
  parameter int unsigned GPR_ADDR_WIDTH = 5,
  parameter int unsigned GPR_NUM        = 32,
  parameter int unsigned LSU_FIFO_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      iss_valid,
  input  logic                      iss_long,
  input  logic [GPR_ADDR_WIDTH-1:0] iss_rd,
  output logic                      iss_stall,
  input  logic [GPR_ADDR_WIDTH-1:0] chk_addr_0,
  input  logic [GPR_ADDR_WIDTH-1:0] chk_addr_1,
  output logic                      hazard_0,
  output logic                      hazard_1,
  input  logic                      alu_valid,
  input  logic [GPR_ADDR_WIDTH-1:0] alu_rd,
  input  logic [WORD_WIDTH-1:0]     alu_data,
  input  logic                      lsu_valid,
  output logic                      lsu_ready,
  input  logic [GPR_ADDR_WIDTH-1:0] lsu_rd,
  input  logic [WORD_WIDTH-1:0]     lsu_data,
  output logic                      we_n,
  output logic [GPR_ADDR_WIDTH-1:0] wr_addr,
  output logic [WORD_WIDTH-1:0]     wr_data,
  output logic [GPR_NUM-1:0]        busy_vec,
  output logic [31:0]               perf_wr_cnt,
  output logic [31:0]               perf_lsu_blk_cnt
);

  localparam int unsigned PTR_WIDTH = $clog2(LSU_FIFO_DEPTH);
  localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;

  logic [GPR_ADDR_WIDTH-1:0] fifo_rd   [LSU_FIFO_DEPTH];
  logic [WORD_WIDTH-1:0]     fifo_data [LSU_FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]      wr_ptr;
  logic [PTR_WIDTH-1:0]      rd_ptr;
  logic [CNT_WIDTH-1:0]      count;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      push;
  logic                      pop;
  logic                      sel_valid;
  logic                      sel_write;
  logic [GPR_ADDR_WIDTH-1:0] sel_rd;
  logic [WORD_WIDTH-1:0]     sel_data;
  logic [GPR_NUM-1:0]        set_mask;
  logic [GPR_NUM-1:0]        clr_mask;

  // Ready depends only on current occupancy; a same-cycle pop does not raise it.
  assign fifo_full  = (count == CNT_WIDTH'(LSU_FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign lsu_ready  = !fifo_full;
  assign push       = lsu_valid && !fifo_full;
  assign pop        = !alu_valid && !fifo_empty;

  assign hazard_0  = busy_vec[chk_addr_0];
  assign hazard_1  = busy_vec[chk_addr_1];
  assign iss_stall = busy_vec[iss_rd];

  // Write-port arbitration: ALU first, else FIFO head; rd=0 consumes the slot silently.
  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    if (alu_valid) begin
      sel_valid = 1'b1;
      sel_rd    = alu_rd;
      sel_data  = alu_data;
    end else if (!fifo_empty) begin
      sel_valid = 1'b1;
      sel_rd    = fifo_rd[rd_ptr];
      sel_data  = fifo_data[rd_ptr];
    end
    sel_write = sel_valid && (sel_rd != '0);
  end

  // Scoreboard set/clear masks; set is applied after clear so it wins.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (iss_valid && iss_long && (iss_rd != '0)) begin
      set_mask = GPR_NUM'(1) << iss_rd;
    end
    if (pop) begin
      clr_mask = GPR_NUM'(1) << fifo_rd[rd_ptr];
    end
  end

  // Registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_n    <= 1'b1;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      we_n <= !sel_write;
      if (sel_valid) begin
        wr_addr <= sel_rd;
        wr_data <= sel_data;
      end
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_vec <= '0;
    end else begin
      busy_vec <= (busy_vec & ~clr_mask) | set_mask;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_WIDTH'(1);
      end else if (pop && !push) begin
        count <= count - CNT_WIDTH'(1);
      end
    end
  end

  // FIFO storage, no reset needed: entries are only read when counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= lsu_rd;
      fifo_data[wr_ptr] <= lsu_data;
    end
  end

`ifdef GPR_WB_PERF_CNT_EN
  // Free-running event counters: real writes and ALU-blocked LSU cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_wr_cnt      <= '0;
      perf_lsu_blk_cnt <= '0;
    end else begin
      if (sel_write) begin
        perf_wr_cnt <= perf_wr_cnt + 32'd1;
      end
      if (alu_valid && !fifo_empty) begin
        perf_lsu_blk_cnt <= perf_lsu_blk_cnt + 32'd1;
      end
    end
  end
`else
  assign perf_wr_cnt      = '0;
  assign perf_lsu_blk_cnt = '0;
`endif

endmodule

// File: tb/tb_gpr_wb_ctrl.sv
// Testbench for gpr_wb_ctrl: directed stimulus, queue-based reference model
// compared every cycle, plus literal expectations at key points.
module tb_gpr_wb_ctrl;

  localparam int unsigned DEPTH = 2;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iss_valid = 1'b0;
  logic        iss_long = 1'b0;
  logic [4:0]  iss_rd = '0;
  logic        iss_stall;
  logic [4:0]  chk_addr_0 = '0;
  logic [4:0]  chk_addr_1 = '0;
  logic        hazard_0;
  logic        hazard_1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic [4:0]  lsu_rd = '0;
  logic [31:0] lsu_data = '0;
  logic        we_n;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] busy_vec;
  logic [31:0] perf_wr_cnt;
  logic [31:0] perf_lsu_blk_cnt;

  int checks = 0;
  int errors = 0;

  gpr_wb_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_long(iss_long), .iss_rd(iss_rd), .iss_stall(iss_stall),
    .chk_addr_0(chk_addr_0), .chk_addr_1(chk_addr_1),
    .hazard_0(hazard_0), .hazard_1(hazard_1),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .we_n(we_n), .wr_addr(wr_addr), .wr_data(wr_data), .busy_vec(busy_vec),
    .perf_wr_cnt(perf_wr_cnt), .perf_lsu_blk_cnt(perf_lsu_blk_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state
  ent_t        m_q[$];
  logic [31:0] m_busy = '0;
  logic        m_we_n = 1'b1;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  bit          m_addr_known = 1'b1;
  logic [31:0] m_wr_cnt = '0;
  logic [31:0] m_blk_cnt = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the write port and scoreboard must hold after each edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_busy       = '0;
      m_we_n       = 1'b1;
      m_addr       = '0;
      m_data       = '0;
      m_addr_known = 1'b1;
      m_wr_cnt     = '0;
      m_blk_cnt    = '0;
    end else begin
      bit   can_push;
      bit   have_sel;
      ent_t sel;
      ent_t head;
      can_push = lsu_valid && (m_q.size() < DEPTH);
      have_sel = 1'b0;
      sel      = '0;
      if (alu_valid) begin
        have_sel = 1'b1;
        sel.rd   = alu_rd;
        sel.data = alu_data;
        if (m_q.size() > 0) m_blk_cnt++;
      end else if (m_q.size() > 0) begin
        head = m_q.pop_front();
        have_sel = 1'b1;
        sel = head;
        m_busy[head.rd] = 1'b0;
      end
      if (can_push) m_q.push_back('{rd: lsu_rd, data: lsu_data});
      if (iss_valid && iss_long && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
      if (have_sel && sel.rd != 5'd0) begin
        m_we_n = 1'b0;
        m_addr = sel.rd;
        m_data = sel.data;
        m_addr_known = 1'b1;
        m_wr_cnt++;
      end else begin
        m_we_n = 1'b1;
        if (have_sel) m_addr_known = 1'b0;
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    chk("we_n", 64'(we_n), 64'(m_we_n));
    if (m_addr_known) begin
      chk("wr_addr", 64'(wr_addr), 64'(m_addr));
      chk("wr_data", 64'(wr_data), 64'(m_data));
    end
    chk("busy_vec", 64'(busy_vec), 64'(m_busy));
    chk("lsu_ready", 64'(lsu_ready), 64'(m_q.size() < DEPTH));
    chk("hazard_0", 64'(hazard_0), 64'(m_busy[chk_addr_0]));
    chk("hazard_1", 64'(hazard_1), 64'(m_busy[chk_addr_1]));
    chk("iss_stall", 64'(iss_stall), 64'(m_busy[iss_rd]));
`ifdef GPR_WB_PERF_CNT_EN
    chk("perf_wr_cnt", 64'(perf_wr_cnt), 64'(m_wr_cnt));
    chk("perf_lsu_blk_cnt", 64'(perf_lsu_blk_cnt), 64'(m_blk_cnt));
`else
    chk("perf_wr_cnt", 64'(perf_wr_cnt), 64'd0);
    chk("perf_lsu_blk_cnt", 64'(perf_lsu_blk_cnt), 64'd0);
`endif
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_valid = 1'b0;
    iss_long  = 1'b0;
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] d);
    alu_valid = 1'b1;
    alu_rd    = rd;
    alu_data  = d;
  endtask

  task automatic lsu(input logic [4:0] rd, input logic [31:0] d);
    lsu_valid = 1'b1;
    lsu_rd    = rd;
    lsu_data  = d;
  endtask

  task automatic issue_long(input logic [4:0] rd);
    iss_valid = 1'b1;
    iss_long  = 1'b1;
    iss_rd    = rd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (3) cyc();
    chk("rst_we_n", 64'(we_n), 64'd1);
    chk("rst_busy", 64'(busy_vec), 64'd0);
    chk("rst_ready", 64'(lsu_ready), 64'd1);
    chk("rst_addr", 64'(wr_addr), 64'd0);
    rst_n = 1'b1;
    cyc();

    // Single ALU write, then hold
    alu(5'd5, 32'hDEADBEEF);
    cyc();
    idle();
    chk("alu_we_n", 64'(we_n), 64'd0);
    chk("alu_addr", 64'(wr_addr), 64'd5);
    chk("alu_data", 64'(wr_data), 64'hDEADBEEF);
    cyc();
    chk("idle_we_n", 64'(we_n), 64'd1);
    chk("idle_addr_hold", 64'(wr_addr), 64'd5);

    // Long issue, hazard, LSU return clears busy
    chk_addr_0 = 5'd7;
    issue_long(5'd7);
    cyc();
    idle();
    chk("long_busy7", 64'(busy_vec[7]), 64'd1);
    chk("long_hazard0", 64'(hazard_0), 64'd1);
    chk("long_stall", 64'(iss_stall), 64'd1);
    lsu(5'd7, 32'h11);
    cyc();
    idle();
    chk("push_we_n", 64'(we_n), 64'd1);
    cyc();
    chk("pop_we_n", 64'(we_n), 64'd0);
    chk("pop_addr", 64'(wr_addr), 64'd7);
    chk("pop_data", 64'(wr_data), 64'h11);
    chk("pop_busy7", 64'(busy_vec[7]), 64'd0);
    chk("pop_hazard0", 64'(hazard_0), 64'd0);

    // Two LSU results blocked by three ALU writes
    lsu(5'd3, 32'h33);
    cyc();
    lsu(5'd4, 32'h44);
    alu(5'd10, 32'hA0);
    cyc();
    lsu_valid = 1'b0;
    chk("blk_ready0", 64'(lsu_ready), 64'd0);
    chk("blk_addr10", 64'(wr_addr), 64'd10);
    alu(5'd11, 32'hA1);
    cyc();
    chk("blk_addr11", 64'(wr_addr), 64'd11);
    alu(5'd12, 32'hA2);
    cyc();
    idle();
    chk("blk_addr12", 64'(wr_addr), 64'd12);
    chk("blk_ready_still0", 64'(lsu_ready), 64'd0);
    cyc();
    chk("drain_addr3", 64'(wr_addr), 64'd3);
    chk("drain_data3", 64'(wr_data), 64'h33);
    chk("drain_ready1", 64'(lsu_ready), 64'd1);
    cyc();
    chk("drain_addr4", 64'(wr_addr), 64'd4);
    chk("drain_data4", 64'(wr_data), 64'h44);
    cyc();
    chk("drain_idle", 64'(we_n), 64'd1);
`ifdef GPR_WB_PERF_CNT_EN
    chk("perf_wr_lit", 64'(perf_wr_cnt), 64'd7);
    chk("perf_blk_lit", 64'(perf_lsu_blk_cnt), 64'd3);
`else
    chk("perf_wr_tied", 64'(perf_wr_cnt), 64'd0);
`endif

    // Re-issue on the same edge as the pop for the same register: set wins
    chk_addr_1 = 5'd9;
    issue_long(5'd9);
    cyc();
    idle();
    lsu(5'd9, 32'h99);
    cyc();
    idle();
    issue_long(5'd9);
    cyc();
    idle();
    chk("same_edge_we_n", 64'(we_n), 64'd0);
    chk("same_edge_addr", 64'(wr_addr), 64'd9);
    chk("same_edge_busy9", 64'(busy_vec[9]), 64'd1);
    chk("same_edge_hazard1", 64'(hazard_1), 64'd1);

    // Register 0 writes are suppressed but consume the slot
    alu(5'd0, 32'h55);
    cyc();
    idle();
    chk("r0_alu_we_n", 64'(we_n), 64'd1);
    lsu(5'd0, 32'h66);
    cyc();
    lsu(5'd6, 32'h77);
    cyc();
    idle();
    chk("r0_lsu_we_n", 64'(we_n), 64'd1);
    cyc();
    chk("after_r0_addr", 64'(wr_addr), 64'd6);
    chk("after_r0_data", 64'(wr_data), 64'h77);
    cyc();

    // Simultaneous push/pop keeps occupancy and order; pointers wrap
    lsu(5'd1, 32'h101);
    cyc();
    lsu(5'd2, 32'h202);
    cyc();
    chk("pp_addr1", 64'(wr_addr), 64'd1);
    chk("pp_ready", 64'(lsu_ready), 64'd1);
    lsu(5'd13, 32'h313);
    cyc();
    idle();
    chk("pp_addr2", 64'(wr_addr), 64'd2);
    cyc();
    chk("pp_addr13", 64'(wr_addr), 64'd13);
    chk("pp_data13", 64'(wr_data), 64'h313);
    cyc();

    // Asynchronous reset mid-operation discards FIFO and scoreboard
    issue_long(5'd20);
    alu(5'd14, 32'hE0);
    lsu(5'd20, 32'h2020);
    cyc();
    alu(5'd15, 32'hE1);
    lsu(5'd21, 32'h2121);
    cyc();
    idle();
    chk("pre_rst_we_n", 64'(we_n), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_we_n", 64'(we_n), 64'd1);
    chk("async_rst_busy", 64'(busy_vec), 64'd0);
    chk("async_rst_ready", 64'(lsu_ready), 64'd1);
    cyc();
    rst_n = 1'b1;
    cyc();
    cyc();
    chk("post_rst_we_n", 64'(we_n), 64'd1);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
